// File: rtl/bcd_add_controller.sv
// bcd_add_controller: initiator FSM for the bcd_add_datapath req/ack interface.
// Steps through LOAD_A, LOAD_B, DISP_A, DISP_B, DISP_LS, DISP_MS, using one
// four-phase handshake per step. A handshake half (REQ or REL) that stays
// stuck for TIMEOUT cycles moves the FSM to ERR.
// Optional feature macro: AUTO_RUN_EN. When it is defined, the display phases
// advance on their own after DWELL_CYCLES cycles instead of waiting for a step.
module bcd_add_controller #(
  parameter int TIMEOUT      = 256,
`ifdef AUTO_RUN_EN
  parameter int DWELL_CYCLES = 1000,
`endif
  parameter int CNT_W        = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       step,
  output logic       load_a,
  output logic       load_b,
  output logic       display_a,
  output logic       display_b,
  output logic       display_ls,
  output logic       display_ms,
  input  logic       load_a_ack,
  input  logic       load_b_ack,
  input  logic       display_a_ack,
  input  logic       display_b_ack,
  input  logic       display_ls_ack,
  input  logic       display_ms_ack,
  output logic [2:0] phase,
  output logic       busy,
  output logic       error
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_REL   = 3'd2,
    ST_DWELL = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
`ifdef AUTO_RUN_EN
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
`endif

  // One-hot request pattern for a phase; bit order matches the ack vector.
  function automatic logic [5:0] phase_req(input logic [2:0] p);
    logic [5:0] r;
    case (p)
      3'd0:    r = 6'b000001;
      3'd1:    r = 6'b000010;
      3'd2:    r = 6'b000100;
      3'd3:    r = 6'b001000;
      3'd4:    r = 6'b010000;
      3'd5:    r = 6'b100000;
      default: r = 6'b000000;
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [5:0]       req_q, req_d;
  logic             busy_q, busy_d;
  logic             error_q, error_d;
  logic             step_q;
`ifdef AUTO_RUN_EN
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
`endif

  logic [5:0] ack_s;
  logic       ack_sel_s;
  logic       step_rise_s;
  logic       tmo_s;

  assign ack_s       = {display_ms_ack, display_ls_ack, display_b_ack,
                        display_a_ack, load_b_ack, load_a_ack};
  // Only the ack that belongs to the current phase takes part in the handshake.
  assign ack_sel_s   = |(ack_s & phase_req(phase_q));
  assign step_rise_s = step & ~step_q;
  assign tmo_s       = (tcnt_q == TMO_LAST);

  // Next-state logic: handshake sequencing, timeout and phase advance.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    tcnt_d  = tcnt_q;
    req_d   = req_q;
`ifdef AUTO_RUN_EN
    dcnt_d  = dcnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (step_rise_s) begin
          state_d = ST_REQ;
          tcnt_d  = {CNT_W{1'b0}};
          req_d   = phase_req(phase_q);
        end else begin
          req_d   = 6'b000000;
        end
      end
      ST_REQ: begin
        // A transition on the same edge as the timeout takes priority.
        if (ack_sel_s) begin
          state_d = ST_REL;
          tcnt_d  = {CNT_W{1'b0}};
          req_d   = 6'b000000;
        end else if (tmo_s) begin
          state_d = ST_ERR;
          req_d   = 6'b000000;
        end else begin
          tcnt_d  = tcnt_q + CNT_W'(1);
        end
      end
      ST_REL: begin
        if (!ack_sel_s) begin
          tcnt_d = {CNT_W{1'b0}};
          if (phase_q < 3'd2) begin
            phase_d = phase_q + 3'd1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DWELL;
`ifdef AUTO_RUN_EN
            dcnt_d  = {CNT_W{1'b0}};
`endif
          end
        end else if (tmo_s) begin
          state_d = ST_ERR;
          req_d   = 6'b000000;
        end else begin
          tcnt_d  = tcnt_q + CNT_W'(1);
        end
      end
      ST_DWELL: begin
`ifdef AUTO_RUN_EN
        // Steps are ignored here; the dwell counter alone decides when to move on.
        if (dcnt_q == DWELL_LAST) begin
`else
        if (step_rise_s) begin
`endif
          if (phase_q == 3'd5) begin
            phase_d = 3'd0;
            state_d = ST_IDLE;
          end else begin
            phase_d = phase_q + 3'd1;
            state_d = ST_REQ;
            tcnt_d  = {CNT_W{1'b0}};
            req_d   = phase_req(phase_q + 3'd1);
          end
        end else begin
`ifdef AUTO_RUN_EN
          dcnt_d  = dcnt_q + CNT_W'(1);
`else
          state_d = ST_DWELL;
`endif
        end
      end
      ST_ERR: begin
        // Recovery needs every responder quiet, otherwise the FSM stays in ERR.
        if (step_rise_s && (ack_s == 6'b000000)) begin
          state_d = ST_IDLE;
          phase_d = 3'd0;
        end else begin
          req_d   = 6'b000000;
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = 3'd0;
        req_d   = 6'b000000;
      end
    endcase
    busy_d  = (state_d == ST_REQ) || (state_d == ST_REL);
    error_d = (state_d == ST_ERR);
  end

  // State and output registers; reset drops every request immediately.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      phase_q <= 3'd0;
      tcnt_q  <= {CNT_W{1'b0}};
      req_q   <= 6'b000000;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
      step_q  <= 1'b0;
`ifdef AUTO_RUN_EN
      dcnt_q  <= {CNT_W{1'b0}};
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      tcnt_q  <= tcnt_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      error_q <= error_d;
      step_q  <= step;
`ifdef AUTO_RUN_EN
      dcnt_q  <= dcnt_d;
`endif
    end
  end

  assign load_a     = req_q[0];
  assign load_b     = req_q[1];
  assign display_a  = req_q[2];
  assign display_b  = req_q[3];
  assign display_ls = req_q[4];
  assign display_ms = req_q[5];
  assign phase      = phase_q;
  assign busy       = busy_q;
  assign error      = error_q;

endmodule

// File: tb/tb_bcd_add_controller.sv
// Scoreboard bench for bcd_add_controller. The stimulus queues the expected
// output changes: the request vector, phase, busy and error, plus the cycle
// distance from the previous change where that distance matters. A monitor
// compares each observed change with the next queued entry.
module tb_bcd_add_controller;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic step = 1'b0;
  logic load_a, load_b, display_a, display_b, display_ls, display_ms;
  logic load_a_ack, load_b_ack, display_a_ack, display_b_ack, display_ls_ack, display_ms_ack;
  logic [2:0] phase;
  logic busy, error;

  always #5 CLK = ~CLK;

`ifdef AUTO_RUN_EN
  bcd_add_controller #(.TIMEOUT(256), .DWELL_CYCLES(4), .CNT_W(16)) dut (
`else
  bcd_add_controller #(.TIMEOUT(256), .CNT_W(16)) dut (
`endif
    .CLK(CLK), .RESET_N(RESET_N), .step(step),
    .load_a(load_a), .load_b(load_b), .display_a(display_a), .display_b(display_b),
    .display_ls(display_ls), .display_ms(display_ms),
    .load_a_ack(load_a_ack), .load_b_ack(load_b_ack), .display_a_ack(display_a_ack),
    .display_b_ack(display_b_ack), .display_ls_ack(display_ls_ack), .display_ms_ack(display_ms_ack),
    .phase(phase), .busy(busy), .error(error));

  // Responder: 0 = zero latency, 1 = delayed by lat cycles, 2 = never acks, 3 = all acks high.
  int mode = 0;
  int lat = 1;
  int wait_cnt = 0;
  logic [5:0] req_v, ack_v, ack_dly;
  assign req_v = {display_ms, display_ls, display_b, display_a, load_b, load_a};
  always_comb begin
    case (mode)
      0:       ack_v = req_v;
      1:       ack_v = ack_dly;
      3:       ack_v = 6'b111111;
      default: ack_v = 6'b000000;
    endcase
  end
  assign {display_ms_ack, display_ls_ack, display_b_ack, display_a_ack, load_b_ack, load_a_ack} = ack_v;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ack_dly <= 6'b000000;
      wait_cnt <= 0;
    end else if (req_v != ack_dly) begin
      if (wait_cnt >= lat - 1) begin
        ack_dly <= req_v;
        wait_cnt <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  typedef struct {
    logic [5:0] req;
    logic [2:0] ph;
    logic       bsy;
    logic       err;
    int         dt;
  } ev_t;

  ev_t exp_q[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int cyc = 0;
  int last_cyc = 0;
  logic [10:0] prev_t = 11'd0;

  function automatic void expect_ev(input logic [5:0] r, input logic [2:0] p,
                                    input logic b, input logic e, input int dt);
    ev_t ev;
    ev.req = r; ev.ph = p; ev.bsy = b; ev.err = e; ev.dt = dt;
    exp_q.push_back(ev);
  endfunction

  // Monitor: per-cycle request legality plus an in-order compare of every output change.
  always @(negedge CLK) begin
    logic [10:0] cur_t;
    ev_t ev;
    cyc = cyc + 1;
    cur_t = {req_v, phase, busy, error};
    if (mon_en) begin
      checks++;
      if (!$onehot0(req_v) || (req_v != 6'b000000 && req_v != (6'b000001 << phase))) begin
        errors++;
        $display("FAIL req_legal: got req=%b phase=%0d", req_v, phase);
      end
      if (cur_t != prev_t) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got req=%b phase=%0d busy=%b err=%b", req_v, phase, busy, error);
        end else begin
          ev = exp_q.pop_front();
          if (req_v != ev.req || phase != ev.ph || busy != ev.bsy || error != ev.err ||
              (ev.dt >= 0 && (cyc - last_cyc) != ev.dt)) begin
            errors++;
            $display("FAIL output_change: got req=%b phase=%0d busy=%b err=%b dt=%0d, want req=%b phase=%0d busy=%b err=%b dt=%0d",
                     req_v, phase, busy, error, cyc - last_cyc, ev.req, ev.ph, ev.bsy, ev.err, ev.dt);
          end
        end
        last_cyc = cyc;
      end
    end
    prev_t = cur_t;
  end

  task automatic step_pulse();
    @(negedge CLK);
    step = 1'b1;
    @(negedge CLK);
    step = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout with %0d expected changes still pending, want 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    checks++;
    if ({req_v, phase, busy, error} != 11'd0) begin
      errors++;
      $display("FAIL reset_state: got req=%b phase=%0d busy=%b err=%b, want all 0", req_v, phase, busy, error);
    end
    prev_t = {req_v, phase, busy, error};
    mon_en = 1'b1;

    // 1: LOAD_A with a responder that answers one cycle after the request.
    mode = 1; lat = 1;
    expect_ev(6'b000001, 3'd0, 1'b1, 1'b0, -1);
    expect_ev(6'b000000, 3'd0, 1'b1, 1'b0, 2);
    expect_ev(6'b000000, 3'd1, 1'b0, 1'b0, 2);
    step_pulse();
    drain("t1_load_a", 50);

    // 2: remaining phases with a zero-latency responder, wrapping back to phase 0.
    mode = 0;
    expect_ev(6'b000010, 3'd1, 1'b1, 1'b0, -1);
    expect_ev(6'b000000, 3'd1, 1'b1, 1'b0, 1);
    expect_ev(6'b000000, 3'd2, 1'b0, 1'b0, 1);
    step_pulse();
    drain("t2_load_b", 50);
`ifdef AUTO_RUN_EN
    expect_ev(6'b000100, 3'd2, 1'b1, 1'b0, -1);
    expect_ev(6'b000000, 3'd2, 1'b1, 1'b0, 1);
    expect_ev(6'b000000, 3'd2, 1'b0, 1'b0, 1);
    for (int p = 3; p <= 5; p++) begin
      expect_ev(6'b000001 << p, 3'(p), 1'b1, 1'b0, 4);
      expect_ev(6'b000000, 3'(p), 1'b1, 1'b0, 1);
      expect_ev(6'b000000, 3'(p), 1'b0, 1'b0, 1);
    end
    expect_ev(6'b000000, 3'd0, 1'b0, 1'b0, 4);
    step_pulse();
    drain("t6_auto_run", 200);
`else
    for (int p = 2; p <= 5; p++) begin
      expect_ev(6'b000001 << p, 3'(p), 1'b1, 1'b0, -1);
      expect_ev(6'b000000, 3'(p), 1'b1, 1'b0, 1);
      expect_ev(6'b000000, 3'(p), 1'b0, 1'b0, 1);
      step_pulse();
      drain("t2_display", 50);
    end
    expect_ev(6'b000000, 3'd0, 1'b0, 1'b0, -1);
    step_pulse();
    drain("t2_wrap", 50);
`endif

    // 3: responder never acks -> ERR after 256 cycles; exit blocked while any ack is high.
    mode = 2;
    expect_ev(6'b000001, 3'd0, 1'b1, 1'b0, -1);
    expect_ev(6'b000000, 3'd0, 1'b0, 1'b1, 256);
    step_pulse();
    drain("t3_timeout", 400);
    mode = 3;
    step_pulse();
    repeat (5) @(negedge CLK);
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL t3_err_hold: got error=%b, want 1", error);
    end
    mode = 2;
    expect_ev(6'b000000, 3'd0, 1'b0, 1'b0, -1);
    step_pulse();
    drain("t3_err_exit", 50);

    // 4: reset asserted while load_b waits for its ack.
    mode = 0;
    expect_ev(6'b000001, 3'd0, 1'b1, 1'b0, -1);
    expect_ev(6'b000000, 3'd0, 1'b1, 1'b0, 1);
    expect_ev(6'b000000, 3'd1, 1'b0, 1'b0, 1);
    step_pulse();
    drain("t4_load_a", 50);
    mode = 2;
    expect_ev(6'b000010, 3'd1, 1'b1, 1'b0, -1);
    step_pulse();
    drain("t4_load_b_req", 50);
    expect_ev(6'b000000, 3'd0, 1'b0, 1'b0, -1);
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if (load_b !== 1'b0) begin
      errors++;
      $display("FAIL t4_async_drop: got load_b=%b, want 0", load_b);
    end
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    drain("t4_reset", 10);
    mode = 0;
    expect_ev(6'b000001, 3'd0, 1'b1, 1'b0, -1);
    expect_ev(6'b000000, 3'd0, 1'b1, 1'b0, 1);
    expect_ev(6'b000000, 3'd1, 1'b0, 1'b0, 1);
    step_pulse();
    drain("t4_after_reset", 50);

    // 5: steps during REQ and REL are dropped; exactly one advance.
    mode = 1; lat = 10;
    expect_ev(6'b000010, 3'd1, 1'b1, 1'b0, -1);
    expect_ev(6'b000000, 3'd1, 1'b1, 1'b0, 11);
    expect_ev(6'b000000, 3'd2, 1'b0, 1'b0, 11);
    step_pulse();
    repeat (3) @(negedge CLK);
    step_pulse();
    repeat (8) @(negedge CLK);
    step_pulse();
    drain("t5_step_drop", 100);
    repeat (10) @(negedge CLK);
    checks++;
    if (phase !== 3'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t5_final: got phase=%0d busy=%b, want phase=2 busy=0", phase, busy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
